// File: rtl/i2s_voice_mixer_scheduler_if.sv
// i2s_voice_mixer_scheduler_if
// Bundles the per-voice valid/ready handshake and the packed stereo sample
// buses that run between the voice generators and the mixer scheduler.
//
// Signals:
//   Voice_Valid  [NUM_VOICES]    per-voice sample valid (voice -> mixer)
//   Voice_Left   [NUM_VOICES*W]  packed left samples, voice k at [k*W +: W]
//   Voice_Right  [NUM_VOICES*W]  packed right samples, same packing
//   Voice_Ready  [NUM_VOICES]    one-hot grant (mixer -> voice)
//
// Modports:
//   master  the voice-generator side (drives valid and samples)
//   slave   the mixer side (drives ready)
interface i2s_voice_mixer_scheduler_if #(
   parameter int NUM_VOICES            = 4,
   parameter int NUM_OF_AMPLITUDE_BITS = 16
);
   logic [NUM_VOICES-1:0]                       Voice_Valid;
   logic [NUM_VOICES*NUM_OF_AMPLITUDE_BITS-1:0] Voice_Left;
   logic [NUM_VOICES*NUM_OF_AMPLITUDE_BITS-1:0] Voice_Right;
   logic [NUM_VOICES-1:0]                       Voice_Ready;

   modport master (
      output Voice_Valid,
      output Voice_Left,
      output Voice_Right,
      input  Voice_Ready
   );

   modport slave (
      input  Voice_Valid,
      input  Voice_Left,
      input  Voice_Right,
      output Voice_Ready
   );
endinterface

// File: rtl/i2s_voice_mixer_scheduler.sv
// i2s_voice_mixer_scheduler
// Once per audio frame (LRCLK falling edge) this block collects one stereo
// sample from each voice over a valid/ready handshake, sums them in signed
// arithmetic and publishes the mix on the I2S transmitter's parallel inputs.
//
// Ports:
//   i_Clk           system clock, shared with the I2S transmitter
//   i_Reset         asynchronous active-high reset
//   i_LRCLK         transmitter LRCLK, synchronous to i_Clk
//   voiceBus        slave side of the voice handshake interface
//   o_Left/o_Right  mixed samples, held for a whole frame
//   o_Frame_Strobe  one-cycle pulse when the mixed samples update
//   o_Missed        voices that did not transfer in the closing frame
//   o_Clip          either channel saturated in the closing frame
//
// Optional feature macro: I2S_MIX_SATURATE_EN
//   defined   -> published samples clamp to the W-bit signed range and
//                o_Clip reports saturation
//   undefined -> published samples wrap (low W bits), o_Clip stays 0
module i2s_voice_mixer_scheduler #(
   parameter int NUM_VOICES            = 4,
   parameter int NUM_OF_AMPLITUDE_BITS = 16
) (
   input  logic                             i_Clk,
   input  logic                             i_Reset,
   input  logic                             i_LRCLK,
   i2s_voice_mixer_scheduler_if.slave       voiceBus,
   output logic [NUM_OF_AMPLITUDE_BITS-1:0] o_Left,
   output logic [NUM_OF_AMPLITUDE_BITS-1:0] o_Right,
   output logic                             o_Frame_Strobe,
   output logic [NUM_VOICES-1:0]            o_Missed,
   output logic                             o_Clip
);
   localparam int W  = NUM_OF_AMPLITUDE_BITS;
   localparam int IW = $clog2(NUM_VOICES);
   localparam int AW = W + IW;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t                state_q, state_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [NUM_VOICES-1:0] taken_q, taken_d;
   logic [AW-1:0]         accL_q, accL_d;
   logic [AW-1:0]         accR_q, accR_d;
   logic                  lrclkSamp_q, lrclkPrev_q;
   logic [W-1:0]          left_q, left_d;
   logic [W-1:0]          right_q, right_d;
   logic                  strobe_q, strobe_d;
   logic [NUM_VOICES-1:0] missed_q, missed_d;
   logic                  clip_q, clip_d;

   logic                  frameEdge;
   logic [NUM_VOICES-1:0] readyVec;
   logic                  transfer;
   logic [W-1:0]          sampleL, sampleR;

`ifdef I2S_MIX_SATURATE_EN
   // The accumulator fits in W signed bits only when its top IW+1 bits are
   // all copies of the same sign bit.
   function automatic logic outOfRange(input logic [AW-1:0] acc);
      outOfRange = !((&acc[AW-1:W-1]) || (~|acc[AW-1:W-1]));
   endfunction

   function automatic logic [W-1:0] conv(input logic [AW-1:0] acc);
      if (outOfRange(acc)) begin
         conv = acc[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end else begin
         conv = acc[W-1:0];
      end
   endfunction
`else
   function automatic logic [W-1:0] conv(input logic [AW-1:0] acc);
      conv = acc[W-1:0];
   endfunction
`endif

   // The frame edge is detected from two registered copies of LRCLK, so the
   // publish lands one edge after LRCLK is first sampled low and the ready
   // decode below depends on registered state only.
   assign frameEdge = ~lrclkSamp_q & lrclkPrev_q;

   // Grant decode: only the voice under the scan pointer, only if it has not
   // already transferred this frame, and never in a publish cycle so that a
   // transfer and a publish cannot coincide.
   always_comb begin
      readyVec = '0;
      if ((state_q == SCAN) && !taken_q[idx_q] && !frameEdge) begin
         readyVec[idx_q] = 1'b1;
      end
   end

   assign voiceBus.Voice_Ready = readyVec;
   assign transfer = |(readyVec & voiceBus.Voice_Valid);
   assign sampleL  = voiceBus.Voice_Left[idx_q*W +: W];
   assign sampleR  = voiceBus.Voice_Right[idx_q*W +: W];

   // Next-state logic: a frame edge publishes the closing frame (except out
   // of IDLE, where there is nothing to publish) and restarts the scan;
   // otherwise SCAN accumulates the granted voice and steps the pointer.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      taken_d  = taken_q;
      accL_d   = accL_q;
      accR_d   = accR_q;
      left_d   = left_q;
      right_d  = right_q;
      strobe_d = 1'b0;
      missed_d = missed_q;
      clip_d   = clip_q;
      if (frameEdge) begin
         if (state_q != IDLE) begin
            left_d   = conv(accL_q);
            right_d  = conv(accR_q);
            missed_d = ~taken_q;
`ifdef I2S_MIX_SATURATE_EN
            clip_d   = outOfRange(accL_q) | outOfRange(accR_q);
`else
            clip_d   = 1'b0;
`endif
            strobe_d = 1'b1;
         end
         accL_d  = '0;
         accR_d  = '0;
         taken_d = '0;
         idx_d   = '0;
         state_d = SCAN;
      end else if (state_q == SCAN) begin
         if (transfer) begin
            accL_d = accL_q + {{IW{sampleL[W-1]}}, sampleL};
            accR_d = accR_q + {{IW{sampleR[W-1]}}, sampleR};
            taken_d[idx_q] = 1'b1;
         end
         if (&taken_d) begin
            state_d = DONE;
         end
         idx_d = (idx_q == IW'(NUM_VOICES-1)) ? '0 : idx_q + IW'(1);
      end
   end

   // State and output registers. The previous-LRCLK copies reset high so a
   // low LRCLK right after reset counts as a frame edge out of IDLE.
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         taken_q     <= '0;
         accL_q      <= '0;
         accR_q      <= '0;
         lrclkSamp_q <= 1'b1;
         lrclkPrev_q <= 1'b1;
         left_q      <= '0;
         right_q     <= '0;
         strobe_q    <= 1'b0;
         missed_q    <= '0;
         clip_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         taken_q     <= taken_d;
         accL_q      <= accL_d;
         accR_q      <= accR_d;
         lrclkSamp_q <= i_LRCLK;
         lrclkPrev_q <= lrclkSamp_q;
         left_q      <= left_d;
         right_q     <= right_d;
         strobe_q    <= strobe_d;
         missed_q    <= missed_d;
         clip_q      <= clip_d;
      end
   end

   assign o_Left         = left_q;
   assign o_Right        = right_q;
   assign o_Frame_Strobe = strobe_q;
   assign o_Missed       = missed_q;
   assign o_Clip         = clip_q;
endmodule

// File: tb/tb_i2s_voice_mixer_scheduler.sv
// tb_i2s_voice_mixer_scheduler
// Self-checking bench for i2s_voice_mixer_scheduler (4 voices, 16-bit).
// Frame vectors come from a table of hand-computed mixes; the single-grant,
// reset and post-reset cases are written out as short sequences.
// Expected saturating/wrapping values follow I2S_MIX_SATURATE_EN.
module tb_i2s_voice_mixer_scheduler;
`ifdef I2S_MIX_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        lrclk;
   logic [15:0] oLeft, oRight;
   logic        oStrobe;
   logic [3:0]  oMissed;
   logic        oClip;

   int assertCount = 0;
   int failCount   = 0;

   logic [15:0] capLeft, capRight;
   logic [3:0]  capMissed;
   logic        capClip;
   int          strobes;

   typedef struct packed {
      logic [3:0]  valid;
      logic [63:0] left;
      logic [63:0] right;
      logic [15:0] expLeft;
      logic [15:0] expRight;
      logic [3:0]  expMissed;
      logic        expClip;
   } vec_t;

   vec_t vecs [7];

   i2s_voice_mixer_scheduler_if #(.NUM_VOICES(4), .NUM_OF_AMPLITUDE_BITS(16)) bus ();

   i2s_voice_mixer_scheduler #(.NUM_VOICES(4), .NUM_OF_AMPLITUDE_BITS(16)) dut (
      .i_Clk          (clk),
      .i_Reset        (reset),
      .i_LRCLK        (lrclk),
      .voiceBus       (bus.slave),
      .o_Left         (oLeft),
      .o_Right        (oRight),
      .o_Frame_Strobe (oStrobe),
      .o_Missed       (oMissed),
      .o_Clip         (oClip)
   );

   // Free-running 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] valid, input logic [63:0] left,
                                input logic [63:0] right);
      bus.Voice_Valid = valid;
      bus.Voice_Left  = left;
      bus.Voice_Right = right;
   endtask

   task automatic holdLrclk(input logic level, input int cycles);
      lrclk = level;
      repeat (cycles) @(negedge clk);
   endtask

   // Drops LRCLK to close the frame and watches a bounded window for the
   // publish strobe, capturing the outputs when it fires.
   task automatic closeAndCapture();
      lrclk   = 1'b0;
      strobes = 0;
      repeat (8) begin
         @(negedge clk);
         if (oStrobe) begin
            strobes++;
            capLeft   = oLeft;
            capRight  = oRight;
            capMissed = oMissed;
            capClip   = oClip;
         end
      end
   endtask

   task automatic runVector(input int i);
      applyStimulus(vecs[i].valid, vecs[i].left, vecs[i].right);
      holdLrclk(1'b1, 4);
      holdLrclk(1'b0, 12);
      applyStimulus(4'b0000, 64'h0, 64'h0);
      holdLrclk(1'b1, 4);
      closeAndCapture();
      checkOutput($sformatf("vec%0d strobes", i), strobes, 1);
      checkOutput($sformatf("vec%0d left", i), capLeft, vecs[i].expLeft);
      checkOutput($sformatf("vec%0d right", i), capRight, vecs[i].expRight);
      checkOutput($sformatf("vec%0d missed", i), capMissed, vecs[i].expMissed);
      checkOutput($sformatf("vec%0d clip", i), capClip, vecs[i].expClip);
   endtask

   initial begin
      int   readyCount;
      bit   found;

      vecs[0] = '{4'b1111, {4{16'h1000}}, {4{16'hF000}},
                  16'h4000, 16'hC000, 4'b0000, 1'b0};
      vecs[1] = '{4'b1011, {4{16'h0100}}, 64'h0,
                  16'h0300, 16'h0000, 4'b0100, 1'b0};
      vecs[2] = '{4'b1111, {4{16'h7000}}, {4{16'h0010}},
                  (SAT ? 16'h7FFF : 16'hC000), 16'h0040, 4'b0000, SAT};
      vecs[3] = '{4'b1111, {16'h0000, 16'h0000, 16'h8000, 16'h8000}, 64'h0,
                  (SAT ? 16'h8000 : 16'h0000), 16'h0000, 4'b0000, SAT};
      vecs[4] = '{4'b1111, {16'h0005, 16'h0002, 16'hFFFF, 16'hFFFF},
                  {16'h0000, 16'h0001, 16'h7FFF, 16'h8000},
                  16'h0005, 16'h0000, 4'b0000, 1'b0};
      vecs[5] = '{4'b0000, {4{16'h1111}}, {4{16'h2222}},
                  16'h0000, 16'h0000, 4'b1111, 1'b0};
      vecs[6] = '{4'b1111, 64'h0, {4{16'hC000}},
                  16'h0000, (SAT ? 16'h8000 : 16'h0000), 4'b0000, SAT};

      reset = 1'b1;
      lrclk = 1'b1;
      applyStimulus(4'b0000, 64'h0, 64'h0);
      repeat (3) @(negedge clk);
      checkOutput("reset ready", bus.Voice_Ready, 4'b0000);
      checkOutput("reset left", oLeft, 16'h0000);
      checkOutput("reset right", oRight, 16'h0000);
      checkOutput("reset strobe", oStrobe, 1'b0);
      checkOutput("reset missed", oMissed, 4'b0000);
      checkOutput("reset clip", oClip, 1'b0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         runVector(i);
      end

      // Voice 0 holds valid for the whole frame: exactly one grant.
      applyStimulus(4'b0001, {48'h0, 16'h1234}, {48'h0, 16'h4321});
      holdLrclk(1'b1, 4);
      lrclk = 1'b0;
      readyCount = 0;
      for (int c = 0; c < 16; c++) begin
         if (c == 12) lrclk = 1'b1;
         @(negedge clk);
         if (bus.Voice_Ready[0]) readyCount++;
      end
      checkOutput("hold ready0 pulses", readyCount, 1);
      closeAndCapture();
      checkOutput("hold strobes", strobes, 1);
      checkOutput("hold left", capLeft, 16'h1234);
      checkOutput("hold right", capRight, 16'h4321);
      checkOutput("hold missed", capMissed, 4'b1110);
      checkOutput("hold clip", capClip, 1'b0);

      // Reset while voice 1 is being granted mid-scan.
      applyStimulus(4'b0000, 64'h0, 64'h0);
      found = 1'b0;
      for (int c = 0; c < 12 && !found; c++) begin
         @(negedge clk);
         if (bus.Voice_Ready[1]) found = 1'b1;
      end
      checkOutput("ready1 seen before reset", found, 1'b1);
      #1 reset = 1'b1;
      #1;
      checkOutput("midreset ready", bus.Voice_Ready, 4'b0000);
      checkOutput("midreset left", oLeft, 16'h0000);
      checkOutput("midreset right", oRight, 16'h0000);
      checkOutput("midreset strobe", oStrobe, 1'b0);
      checkOutput("midreset missed", oMissed, 4'b0000);
      checkOutput("midreset clip", oClip, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      // The first edge after reset only starts a scan; nothing is published.
      strobes = 0;
      repeat (8) begin
         @(negedge clk);
         if (oStrobe) strobes++;
      end
      checkOutput("postreset strobes", strobes, 0);

      runVector(0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   // Absolute watchdog so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end
endmodule

// File: doc/i2s_voice_mixer_scheduler.md
# i2s_voice_mixer_scheduler

Frame-synchronous scheduler and mixer that sits between the synthesizer voice generators and the I2S transmitter. Once per audio frame, it collects one stereo sample from each of NUM_VOICES requesters using a valid/ready handshake. It sums the collected samples in signed arithmetic and publishes the mixed left/right words on the transmitter's parallel sample inputs. Frame timing comes from the transmitter's LRCLK, so each published sample is stable for a full frame.

## Interface
- NUM_VOICES, 4: number of voice requesters; must be ≥2.
- NUM_OF_AMPLITUDE_BITS, 16: width W of each signed two's-complement channel sample.
- i_Clk  input  1  system clock; same clock as the I2S transmitter.
- i_Reset  input  1  asynchronous, active-high reset.
- i_LRCLK  input  1  LRCLK from the I2S transmitter, synchronous to i_Clk.
- i_Voice_Valid  input  NUM_VOICES  per-voice sample valid.
- i_Voice_Left  input  NUM_VOICES*W  packed left samples; voice k occupies bits [k*W +: W].
- i_Voice_Right  input  NUM_VOICES*W  packed right samples, same packing.
- o_Voice_Ready  output  NUM_VOICES  one-hot grant; a transfer occurs when valid and ready are both high on the same edge.
- o_Left  output  W  mixed left sample, feeds the transmitter's left sample input.
- o_Right  output  W  mixed right sample, feeds the transmitter's right sample input.
- o_Frame_Strobe  output  1  one-cycle pulse when o_Left/o_Right update.
- o_Missed  output  NUM_VOICES  voices that did not transfer in the closing frame; updated with the strobe.
- o_Clip  output  1  high for the frame if either channel saturated; updated with the strobe.

## Operation
- Frame edge: i_LRCLK sampled 0 while the registered previous value is 1 (LRCLK falling edge marks the left-channel start).
- States:
  - IDLE: after reset; waits for the first frame edge.
  - SCAN: visits voices cyclically.
  - DONE: all voices taken; waits for the next frame edge.
- IDLE → SCAN on frame edge.
- SCAN behaviour:
  - idx visits voice idx, one voice per cycle, wrapping NUM_VOICES-1 → 0.
  - o_Voice_Ready[idx] = 1 only when state is SCAN, taken[idx] = 0, and there is no frame edge this cycle. All other ready bits are 0.
  - On transfer: sign-extend both samples to W+$clog2(NUM_VOICES) bits, add them into accL/accR, and set taken[idx].
  - A voice that is not valid when visited is skipped and revisited on the next pass.
  - SCAN → DONE when every taken bit is set, including the one set this cycle.
- On a frame edge from any state other than IDLE:
  - o_Left ← conv(accL), o_Right ← conv(accR).
  - o_Missed ← ~taken.
  - o_Clip ← clip flag.
  - o_Frame_Strobe ← 1.
  - accL, accR, taken cleared; idx ← 0; state ← SCAN.
- A frame edge has priority over a transfer: ready is forced low during the edge cycle, so a transfer and a publish never coincide.
- A frame that closes mid-scan publishes only the sum of the voices taken so far. Untaken voices contribute 0 and are flagged in o_Missed.
- Each voice transfers at most once per frame, even if its valid stays high.
- Reset mid-operation:
  - Outputs return immediately to reset values.
  - Accumulators and taken are cleared; state ← IDLE; the previous-LRCLK register ← 1.

## Timing
- Reset values: o_Voice_Ready=0, o_Left=0, o_Right=0, o_Frame_Strobe=0, o_Missed=0, o_Clip=0.
- Publish latency: if i_LRCLK is first sampled low at edge t, o_Left/o_Right/o_Missed/o_Clip/o_Frame_Strobe are updated at edge t+1.
- Outputs hold their values until the next publish.
- o_Voice_Ready is decoded from registered state and idx only; it has no combinational path from i_Voice_Valid.
- Scan rate is one voice per cycle, so all voices can be collected within NUM_VOICES cycles of a frame edge if they are valid.

## Configuration
- I2S_MIX_SATURATE_EN defined:
  - conv() clamps to the range [-2^(W-1), 2^(W-1)-1].
  - The clip flag is set if either channel's accumulator lies outside that range.
- I2S_MIX_SATURATE_EN undefined:
  - conv() takes the low W bits of the accumulator (wrap-around).
  - o_Clip is tied to 0.

## Test plan
- Reset asserted mid-SCAN with voice 1 granted → o_Voice_Ready=0, all outputs 0 at once; no publish until the first frame edge after reset release.
- All 4 voices valid, left=0x1000, right=0xF000 → next publish o_Left=0x4000, o_Right=0xC000, o_Missed=4'b0000, o_Clip=0, one strobe.
- Voice 2 valid low for the whole frame, others left=0x0100 → o_Left=0x0300, o_Missed=4'b0100.
- 4 voices at left=0x7000 → with macro: o_Left=0x7FFF, o_Clip=1; without macro: o_Left=0xC000, o_Clip=0.
- 2 voices at left=0x8000, others 0 → with macro: o_Left=0x8000, o_Clip=1.
- Voice 0 holds valid high across a whole frame → exactly one ready pulse on voice 0 per frame; the second pass never grants it.
